// File: rtl/lut_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lut_pkg
//  Description : Shared types and constants for the configurable LUT bank:
//                configuration state encoding, size limits and a depth helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lut_pkg;

    // Configuration state of the bank; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } lut_cfg_state_t;

    localparam int LUT_K_MAX   = 6;
    localparam int LUT_NUM_MAX = 8;

    // Number of truth-table entries of a k-input LUT.
    function automatic int lut_depth(input int k);
        return 1 << k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_mux_k.sv
`default_nettype none
// ============================================================================
//  Module      : lut_mux_k
//  Description : Combinational 2**K:1 multiplexer selecting one truth-table
//                bit of a single K-input LUT.
//  Revision    : 1.0  initial release
// ============================================================================
module lut_mux_k
    import lut_pkg::*;
#(
    parameter int K = 4
) (
    input  logic [lut_depth(K)-1:0] i_table,
    input  logic [K-1:0]            i_sel,
    output logic                    o_bit
);

    // Select indexes the truth table directly.
    assign o_bit = i_table[i_sel];

endmodule
`default_nettype wire

// File: rtl/lut_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lut_cfg_bank
//  Description : Bank of NUM_LUT K-input LUTs with registered outputs. Truth
//                tables are loaded serially over a valid/ready port; the LUTs
//                evaluate only once a full configuration has been shifted in.
//                Optional macro LUT_CFG_CHAIN_EN adds cfg_out, the registered
//                bit shifted out of the configuration, for daisy-chaining.
//  Revision    : 1.0  initial release
// ============================================================================
module lut_cfg_bank
    import lut_pkg::*;
#(
    parameter int K       = 4,   // legal 2..LUT_K_MAX
    parameter int NUM_LUT = 2    // legal 1..LUT_NUM_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_LUT*K-1:0] LUT_sel,
    output logic [NUM_LUT-1:0] LUT_output,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    input  logic               cfg_bit,
    output logic               cfg_ready,
    output logic               cfg_done
`ifdef LUT_CFG_CHAIN_EN
    ,
    output logic               cfg_out
`endif
);

    localparam int DEPTH    = lut_depth(K);
    localparam int CFG_BITS = NUM_LUT * DEPTH;
    localparam int CNT_W    = $clog2(CFG_BITS + 1);

    lut_cfg_state_t      r_state_q, w_state_d;
    logic [CFG_BITS-1:0] r_cfg_q,   w_cfg_d;
    logic [CNT_W-1:0]    r_cnt_q,   w_cnt_d;
    logic                r_ready_q, w_ready_d;
    logic                r_done_q,  w_done_d;
    logic [NUM_LUT-1:0]  r_out_q,   w_out_d;
    logic [NUM_LUT-1:0]  w_lut_val;
    logic                w_accept;

    assign w_accept = cfg_valid && r_ready_q;

    // One mux per LUT, each fed by its own slice of the configuration vector.
    for (genvar j = 0; j < NUM_LUT; j++) begin : g_lut
        lut_mux_k #(.K(K)) u_mux (
            .i_table (r_cfg_q[j*DEPTH +: DEPTH]),
            .i_sel   (LUT_sel[j*K +: K]),
            .o_bit   (w_lut_val[j])
        );
    end

    // Next-state logic: state machine, bit counter, shift register and outputs.
    always_comb begin
        w_state_d = r_state_q;
        w_cfg_d   = r_cfg_q;
        w_cnt_d   = r_cnt_q;

        // The accepted bit is shifted in even when a restart wins the edge.
        if (w_accept) begin
            w_cfg_d = {cfg_bit, r_cfg_q[CFG_BITS-1:1]};
        end

        case (r_state_q)
            LOAD: begin
                if (cfg_start) begin
                    w_cnt_d = '0;
                end else if (w_accept) begin
                    if (r_cnt_q == CNT_W'(CFG_BITS - 1)) begin
                        w_state_d = ACTIVE;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                // UNCFG and ACTIVE behave alike apart from output evaluation.
                if (cfg_start) begin
                    w_state_d = LOAD;
                    w_cnt_d   = '0;
                end
            end
        endcase

        w_ready_d = (w_state_d == LOAD);
        w_done_d  = (w_state_d == ACTIVE);
        w_out_d   = (r_state_q == ACTIVE) ? w_lut_val : '0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= UNCFG;
            r_cfg_q   <= '0;
            r_cnt_q   <= '0;
            r_ready_q <= 1'b0;
            r_done_q  <= 1'b0;
            r_out_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cfg_q   <= w_cfg_d;
            r_cnt_q   <= w_cnt_d;
            r_ready_q <= w_ready_d;
            r_done_q  <= w_done_d;
            r_out_q   <= w_out_d;
        end
    end

    assign LUT_output = r_out_q;
    assign cfg_ready  = r_ready_q;
    assign cfg_done   = r_done_q;

`ifdef LUT_CFG_CHAIN_EN
    logic r_cfg_out_q;

    // Capture the bit leaving index 0 on every accept; hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_out_q <= 1'b0;
        end else if (w_accept) begin
            r_cfg_out_q <= r_cfg_q[0];
        end
    end

    assign cfg_out = r_cfg_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lut_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_cfg_bank
//  Description : Self-checking bench for lut_cfg_bank (K=4, NUM_LUT=2) with a
//                behavioural model of the configuration protocol and LUTs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lut_cfg_bank;

    localparam int K  = 4;
    localparam int NL = 2;
    localparam int CB = 32;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NL*K-1:0] LUT_sel;
    logic [NL-1:0] LUT_output;
    logic          cfg_start, cfg_valid, cfg_bit;
    logic          cfg_ready, cfg_done;
`ifdef LUT_CFG_CHAIN_EN
    logic          cfg_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_cfg_bank #(.K(K), .NUM_LUT(NL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LUT_sel    (LUT_sel),
        .LUT_output (LUT_output),
        .cfg_start  (cfg_start),
        .cfg_valid  (cfg_valid),
        .cfg_bit    (cfg_bit),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done)
`ifdef LUT_CFG_CHAIN_EN
        ,
        .cfg_out    (cfg_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;
    int          m_cnt;     // bits accepted since the last start
    logic [31:0] m_cfg;
    logic [1:0]  m_out;
    logic        m_cout;
    logic        m_acc;

    assign m_acc = cfg_valid && (m_mode == M_LOAD);

    function automatic logic [1:0] lut_eval(input logic [31:0] c, input logic [7:0] s);
        logic [1:0] r;
        r = '0;
        for (int j = 0; j < NL; j++) r[j] = c[j*16 + int'(s[j*4 +: 4])];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_cnt <= 0; m_cfg <= '0; m_out <= '0; m_cout <= 1'b0;
        end else begin
            m_out <= (m_mode == M_RUN) ? lut_eval(m_cfg, LUT_sel) : 2'b00;
            if (m_acc) begin
                m_cfg  <= {cfg_bit, m_cfg[31:1]};
                m_cout <= m_cfg[0];
            end
            if (m_mode != M_LOAD) begin
                if (cfg_start) begin m_mode <= M_LOAD; m_cnt <= 0; end
            end else if (cfg_start) begin
                m_cnt <= 0;
            end else if (m_acc) begin
                if (m_cnt + 1 == CB) begin m_mode <= M_RUN; m_cnt <= 0; end
                else m_cnt <= m_cnt + 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("lut_output", 32'(LUT_output), 32'(m_out));
        chk("cfg_ready",  32'(cfg_ready),  32'(m_mode == M_LOAD));
        chk("cfg_done",   32'(cfg_done),   32'(m_mode == M_RUN));
`ifdef LUT_CFG_CHAIN_EN
        chk("cfg_out",    32'(cfg_out),    32'(m_cout));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input bit junk);
        cfg_start = 1'b1;
        cfg_valid = junk;
        cfg_bit   = 1'($urandom);
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    // Send n bits of w, LSB first; only handshaked bits advance.
    task automatic load(input logic [31:0] w, input int n, input bit gappy);
        int  i = 0;
        int  budget = 0;
        bit  acc;
        while (i < n && budget < 400) begin
            if (gappy && $urandom_range(0, 2) == 0) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom);
            end else begin
                cfg_valid = 1'b1;
                cfg_bit   = w[i];
            end
            acc = cfg_valid && cfg_ready;
            @(negedge clk);
            if (acc) i++;
            budget++;
        end
        cfg_valid = 1'b0;
        chk("load_bits", 32'(i), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; LUT_sel = '0;
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(LUT_output), 32'd0);
        chk("rst_ready", 32'(cfg_ready),  32'd0);
        chk("rst_done",  32'(cfg_done),   32'd0);
        rst_n = 1'b1;

        // Unconfigured: outputs stay 0 whatever the select.
        for (int i = 0; i < 16; i++) begin
            LUT_sel = 8'($urandom);
            @(negedge clk);
            chk("uncfg_out", 32'(LUT_output), 32'd0);
        end

        // Back-to-back load of 0x0001_8000.
        pulse_start(1'b0);
        load(32'h0001_8000, CB, 1'b0);
        chk("load1_done",  32'(cfg_done),  32'd1);
        chk("load1_ready", 32'(cfg_ready), 32'd0);
        LUT_sel = 8'h0F; @(negedge clk);
        chk("load1_sel0F", 32'(LUT_output), 32'b11);
        LUT_sel = 8'h1E; @(negedge clk);
        chk("load1_sel1E", 32'(LUT_output), 32'b00);

        // Same table with gaps and bits offered while not ready.
        repeat (3) begin
            cfg_valid = 1'b1; cfg_bit = 1'($urandom);
            @(negedge clk);
        end
        pulse_start(1'b1);
        chk("reload_done_low", 32'(cfg_done),  32'd0);
        chk("reload_ready",    32'(cfg_ready), 32'd1);
        load(32'h0001_8000, CB, 1'b1);
        LUT_sel = 8'h0F; @(negedge clk);
        chk("load2_sel0F", 32'(LUT_output), 32'b11);
        LUT_sel = 8'h1E; @(negedge clk);
        chk("load2_sel1E", 32'(LUT_output), 32'b00);

        // Restart after 10 bits, then 0xFFFF_0000.
        pulse_start(1'b0);
        load($urandom, 10, 1'b0);
        pulse_start(1'b1);
        load(32'hFFFF_0000, CB, 1'b1);
        for (int i = 0; i < 12; i++) begin
            LUT_sel = 8'($urandom);
            @(negedge clk);
            chk("restart_out", 32'(LUT_output), 32'b10);
        end

        // Asynchronous reset while active clears outputs immediately.
        #2 rst_n = 1'b0;
        #1 chk("arst_active_out", 32'(LUT_output), 32'd0);
        chk("arst_active_done", 32'(cfg_done), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Asynchronous reset mid-load.
        pulse_start(1'b0);
        load($urandom, 20, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("arst_load_ready", 32'(cfg_ready), 32'd0);
        chk("arst_load_out", 32'(LUT_output), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        LUT_sel = 8'($urandom); @(negedge clk);
        chk("post_rst_ready", 32'(cfg_ready), 32'd0);
        chk("post_rst_done",  32'(cfg_done),  32'd0);
        pulse_start(1'b0);
        load(32'h0, CB, 1'b0);
        for (int i = 0; i < 8; i++) begin
            LUT_sel = 8'($urandom);
            @(negedge clk);
            chk("zero_cfg_out", 32'(LUT_output), 32'd0);
        end

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            cfg_start = ($urandom_range(0, 119) == 0);
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_bit   = 1'($urandom);
            LUT_sel   = 8'($urandom);
            @(negedge clk);
        end
        cfg_start = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
